// File: rtl/mem_access_if.sv
// mem_access_if: execute-side handshake, data-bus request/response and writeback-side
// signals of the memory stage. master = surrounding pipeline and bus, slave = mem_access.
interface mem_access_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [31:0] in_wdata;
  logic        in_memread;
  logic        in_memwrite;
  logic        in_signed;
  logic [1:0]  in_size;
  logic [4:0]  in_writereg;
  logic        in_regwrite;

  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic        dreq_write;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_wdata;
  logic        dreq_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_writereg;
  logic        out_regwrite;
  logic        out_exc_adel;
  logic        out_exc_ades;
  logic [31:0] out_badvaddr;

  modport master (
    output in_valid, in_result, in_wdata, in_memread, in_memwrite, in_signed, in_size,
           in_writereg, in_regwrite,
    input  in_ready,
    input  dreq_valid, dreq_addr, dreq_write, dreq_size, dreq_strobe, dreq_wdata,
    output dreq_addr_ok, dresp_data_ok, dresp_data,
    output out_ready,
    input  out_valid, out_result, out_writereg, out_regwrite, out_exc_adel, out_exc_ades,
           out_badvaddr
  );

  modport slave (
    input  in_valid, in_result, in_wdata, in_memread, in_memwrite, in_signed, in_size,
           in_writereg, in_regwrite,
    output in_ready,
    output dreq_valid, dreq_addr, dreq_write, dreq_size, dreq_strobe, dreq_wdata,
    input  dreq_addr_ok, dresp_data_ok, dresp_data,
    input  out_ready,
    output out_valid, out_result, out_writereg, out_regwrite, out_exc_adel, out_exc_ades,
           out_badvaddr
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: memory stage; issues one data-bus request per load/store and hands the result on.
// Define MEM_ADDR_ERR_EN to trap misaligned half/word accesses instead of aligning them.
module mem_access (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  mem_access_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] wdata;
    logic        memread;
    logic        memwrite;
    logic        sext;
    logic [1:0]  size;      // 0 byte, 1 half, 2 word (3 folded to 2 on capture)
    logic [4:0]  writereg;
    logic        regwrite;
  } txn_t;

  state_e      state_q, state_d;
  txn_t        txn_q, txn_d;
  logic [31:0] result_q, result_d;
  logic        drop_q, drop_d;

  logic        in_ready;
  logic        accept;
  logic        is_mem;
  logic        addr_err;
  logic        is_load;
  logic [31:0] addr_al;
  logic [15:0] lane_data;
  logic [31:0] load_val;
  logic [3:0]  strobe;
  logic [31:0] wdata_rep;

  assign is_mem   = bus.in_memread | bus.in_memwrite;
  assign in_ready = ~flush & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;
  assign is_load  = txn_q.memread & ~txn_q.memwrite;

`ifdef MEM_ADDR_ERR_EN
  logic        exc_adel_q, exc_adel_d;
  logic        exc_ades_q, exc_ades_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        misaligned;

  assign misaligned = ((bus.in_size == 2'd1) & bus.in_result[0]) |
                      (bus.in_size[1] & (bus.in_result[1:0] != 2'b00));
  assign addr_err   = is_mem & misaligned;
`else
  assign addr_err   = 1'b0;
`endif

  // Natural alignment of the issued address; misaligned ops never reach the bus when trapped.
  always_comb begin
    addr_al = txn_q.result;
    case (txn_q.size)
      2'd1:    addr_al[0]   = 1'b0;
      2'd2:    addr_al[1:0] = 2'b00;
      default: ;
    endcase
  end

  always_comb begin
    strobe    = 4'b0000;
    wdata_rep = 32'h0;
    if (txn_q.memwrite) begin
      case (txn_q.size)
        2'd0: begin
          strobe    = 4'b0001 << addr_al[1:0];
          wdata_rep = {4{txn_q.wdata[7:0]}};
        end
        2'd1: begin
          strobe    = 4'b0011 << addr_al[1:0];
          wdata_rep = {2{txn_q.wdata[15:0]}};
        end
        default: begin
          strobe    = 4'b1111;
          wdata_rep = txn_q.wdata;
        end
      endcase
    end
  end

  assign lane_data = 16'(bus.dresp_data >> {addr_al[1:0], 3'b000});

  always_comb begin
    case (txn_q.size)
      2'd0:    load_val = {{24{txn_q.sext & lane_data[7]}}, lane_data[7:0]};
      2'd1:    load_val = {{16{txn_q.sext & lane_data[15]}}, lane_data[15:0]};
      default: load_val = bus.dresp_data;
    endcase
  end

  always_comb begin
    // NOTE: every target gets its hold value first, so no path through the case infers a latch.
    state_d  = state_q;
    txn_d    = txn_q;
    result_d = result_q;
    drop_d   = drop_q;
`ifdef MEM_ADDR_ERR_EN
    exc_adel_d = exc_adel_q;
    exc_ades_d = exc_ades_q;
    badvaddr_d = badvaddr_q;
`endif

    unique case (state_q)
      REQ: begin
        if (bus.dreq_addr_ok) begin
          if (bus.dresp_data_ok) begin
            state_d = flush ? IDLE : DONE;
            if (!flush && is_load) result_d = load_val;
          end else begin
            // Bus has taken the request; a flush now can only discard the response.
            state_d = WAIT;
            drop_d  = flush;
          end
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (bus.dresp_data_ok) begin
          drop_d = 1'b0;
          if (drop_q || flush) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            if (is_load) result_d = load_val;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      DONE: begin
        if (flush || bus.out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      txn_d.result   = bus.in_result;
      txn_d.wdata    = bus.in_wdata;
      txn_d.memread  = bus.in_memread;
      txn_d.memwrite = bus.in_memwrite;
      txn_d.sext     = bus.in_signed;
      txn_d.size     = bus.in_size[1] ? 2'd2 : bus.in_size;
      txn_d.writereg = bus.in_writereg;
      txn_d.regwrite = bus.in_regwrite & ~addr_err;
      result_d       = bus.in_result;
      state_d        = (is_mem && !addr_err) ? REQ : DONE;
`ifdef MEM_ADDR_ERR_EN
      exc_adel_d = addr_err & ~bus.in_memwrite;
      exc_ades_d = addr_err & bus.in_memwrite;
      badvaddr_d = addr_err ? bus.in_result : 32'h0;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      txn_q    <= '0;
      result_q <= 32'h0;
      drop_q   <= 1'b0;
`ifdef MEM_ADDR_ERR_EN
      exc_adel_q <= 1'b0;
      exc_ades_q <= 1'b0;
      badvaddr_q <= 32'h0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values computed above.
      state_q  <= state_d;
      txn_q    <= txn_d;
      result_q <= result_d;
      drop_q   <= drop_d;
`ifdef MEM_ADDR_ERR_EN
      exc_adel_q <= exc_adel_d;
      exc_ades_q <= exc_ades_d;
      badvaddr_q <= badvaddr_d;
`endif
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.dreq_valid   = (state_q == REQ);
  assign bus.dreq_addr    = addr_al;
  assign bus.dreq_write   = txn_q.memwrite;
  assign bus.dreq_size    = txn_q.size;
  assign bus.dreq_strobe  = strobe;
  assign bus.dreq_wdata   = wdata_rep;

  assign bus.out_valid    = (state_q == DONE) & ~flush;
  assign bus.out_result   = result_q;
  assign bus.out_writereg = txn_q.writereg;
  assign bus.out_regwrite = txn_q.regwrite;
`ifdef MEM_ADDR_ERR_EN
  assign bus.out_exc_adel = exc_adel_q;
  assign bus.out_exc_ades = exc_ades_q;
  assign bus.out_badvaddr = badvaddr_q;
`else
  assign bus.out_exc_adel = 1'b0;
  assign bus.out_exc_ades = 1'b0;
  assign bus.out_badvaddr = 32'h0;
`endif
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port flush, input, 1: kills the held or in-flight instruction.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream handshake from the execute stage.
REQ-005 SHALL have port in_result, input, 32: ALU result, also used as the memory address.
REQ-006 SHALL have ports in_wdata (input, 32), in_memread (input, 1), in_memwrite (input, 1), in_signed (input, 1).
REQ-007 SHALL have port in_size, input, 2: 0 byte, 1 half, 2 word; 3 is treated as word.
REQ-008 SHALL have ports in_writereg (input, 5) and in_regwrite (input, 1): destination passthrough.
REQ-009 SHALL have port dreq_valid, output, 1: data-bus request valid.
REQ-010 SHALL have port dreq_addr, output, 32.
REQ-011 SHALL have ports dreq_write (output, 1), dreq_size (output, 2), dreq_strobe (output, 4), dreq_wdata (output, 32).
REQ-012 SHALL have ports dreq_addr_ok (input, 1), dresp_data_ok (input, 1), dresp_data (input, 32).
REQ-013 SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream handshake to writeback.
REQ-014 SHALL have ports out_result (output, 32), out_writereg (output, 5), out_regwrite (output, 1).
REQ-015 SHALL have ports out_exc_adel (output, 1), out_exc_ades (output, 1), out_badvaddr (output, 32).

Function
REQ-016 SHALL implement the FSM states IDLE, REQ, WAIT and DONE.
REQ-017 SHALL assert in_ready only in IDLE, or in DONE when out_ready=1 (back-to-back acceptance).
REQ-018 On acceptance, SHALL latch all in_* fields and go to REQ if (memread|memwrite) and no address error; otherwise go to DONE.
REQ-019 In REQ, SHALL hold dreq_valid=1 with stable dreq_* fields, and move to WAIT on the cycle dreq_addr_ok=1.
REQ-020 In WAIT, SHALL move to DONE on dresp_data_ok=1 and capture dresp_data in the same cycle; addr_ok and data_ok arriving in the same cycle go REQ->DONE directly.
REQ-021 For stores, dreq_strobe SHALL be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-022 For stores, dreq_wdata SHALL be the byte/half replicated across lanes; for loads, strobe SHALL be 0000 and dreq_write=0.
REQ-023 For loads, out_result SHALL be the lane selected by addr[1:0], zero- or sign-extended per in_signed; for non-loads, out_result=in_result.
REQ-024 In DONE, SHALL hold out_valid=1 with stable outputs until out_ready=1, then go to IDLE or accept new input.
REQ-025 Total latency for a non-memory op SHALL be 1 cycle (accept->DONE); for a memory op, 2 cycles plus bus wait.
REQ-026 Flush in IDLE, DONE or REQ-before-addr_ok SHALL drop the op and return to IDLE next cycle.
REQ-027 Flush in WAIT (or on the addr_ok cycle) SHALL set a drop flag, stay until data_ok, discard the data, then return to IDLE with out_valid never asserted.
REQ-028 in_ready SHALL be 0 during flush.

Reset
REQ-029 On resetn=0 (asynchronous), SHALL force state IDLE, the drop flag 0, and all latched fields 0.
REQ-030 During and after reset, out_valid=0, dreq_valid=0, exception outputs 0, in_ready=1 once resetn=1.
REQ-031 Reset mid-transaction SHALL abandon the bus op; the bus side is reset by the same resetn.

Configuration
REQ-032 Macro MEM_ADDR_ERR_EN defined: a misaligned half (addr[0]) or word (addr[1:0]!=0) access SHALL set out_exc_adel (load) or out_exc_ades (store), set out_badvaddr=addr, force out_regwrite=0, issue no bus request, and go straight to DONE.
REQ-033 Macro MEM_ADDR_ERR_EN undefined: SHALL tie exception outputs and out_badvaddr to 0, and force the address low bits to natural alignment before issue.

Verification
REQ-034 Non-memory op: in_result=0x1234, regwrite=1 -> out_valid the next cycle with out_result=0x1234 and no dreq_valid.
REQ-035 Load byte, signed, addr=0x80000003, dresp_data=0x80FF0000, addr_ok delayed 2 cycles -> strobe 0000, out_result=0xFFFFFF80 after data_ok.
REQ-036 Store half, addr=0x10, wdata=0xABCD -> dreq_strobe=0011, dreq_wdata=0xABCDABCD, dreq_size=1.
REQ-037 Flush in WAIT, then data_ok 3 cycles later -> no out_valid; in_ready returns 1 the cycle after data_ok.
REQ-038 With MEM_ADDR_ERR_EN, load word addr=0x102 -> out_exc_adel=1, out_badvaddr=0x102, no dreq_valid.
REQ-039 out_ready=0 for 4 cycles in DONE -> outputs stable; resetn pulse mid-WAIT -> IDLE immediately and out_valid=0.
